// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler: double/triple frame-buffer ownership between camera writer and HDMI reader
module frame_buffer_scheduler #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0009_6000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk_100Mhz,
  input  logic             rst,
  input  logic             triple_en,
  input  logic             wr_frame_done,
  input  logic             rd_vsync,
  output logic [31:0]      wr_base_addr,
  output logic [31:0]      rd_base_addr,
  output logic             wr_stall,
  output logic             new_frame,
  output logic [1:0]       wr_idx,
  output logic [1:0]       rd_idx,
  output logic [CNT_W-1:0] frames_shown,
  output logic [CNT_W-1:0] frames_dropped,
  output logic [CNT_W-1:0] frames_repeated
);
  logic [1:0] rdy_idx, wr_n, rd_n, rdy_n;
  logic       rdy_valid, mode, vld_n, stall_n, show, drop, rep;
  always_comb begin
    wr_n = wr_idx;
    rd_n = rd_idx;
    rdy_n = rdy_idx;
    vld_n = rdy_valid;
    stall_n = wr_stall;
    show = 1'b0;
    drop = 1'b0;
    rep = 1'b0;
    if (mode) begin
      if (wr_frame_done && rd_vsync) begin
        // the just-finished frame bypasses the ready slot and goes straight to the reader
        rd_n = wr_idx;
        wr_n = rdy_valid ? rdy_idx : rd_idx;
        rdy_n = rdy_valid ? rd_idx : rdy_idx;
        drop = rdy_valid;
        vld_n = 1'b0;
        show = 1'b1;
      end else if (wr_frame_done) begin
        wr_n = rdy_idx;
        rdy_n = wr_idx;
        vld_n = 1'b1;
        drop = rdy_valid;
      end else if (rd_vsync) begin
        rd_n = rdy_valid ? rdy_idx : rd_idx;
        rdy_n = rdy_valid ? rd_idx : rdy_idx;
        vld_n = 1'b0;
        show = rdy_valid;
        rep = !rdy_valid;
      end
    end else begin
      // a completion while one is already pending is a writer protocol violation
      drop = wr_frame_done && rdy_valid;
      if (rd_vsync && (rdy_valid || wr_frame_done)) begin
        wr_n = rd_idx;
        rd_n = wr_idx;
        vld_n = 1'b0;
        stall_n = 1'b0;
        show = 1'b1;
      end else if (rd_vsync) begin
        rep = 1'b1;
      end else if (wr_frame_done) begin
        vld_n = 1'b1;
        stall_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      mode <= triple_en;
      wr_idx <= 2'd0;
      rd_idx <= 2'd1;
      rdy_idx <= 2'd2;
      rdy_valid <= 1'b0;
      wr_stall <= 1'b0;
      new_frame <= 1'b0;
      frames_shown <= '0;
      frames_dropped <= '0;
      frames_repeated <= '0;
      wr_base_addr <= BASE_ADDR;
      rd_base_addr <= BASE_ADDR + FRAME_BYTES;
    end else begin
      wr_idx <= wr_n;
      rd_idx <= rd_n;
      rdy_idx <= rdy_n;
      rdy_valid <= vld_n;
      wr_stall <= stall_n;
      new_frame <= show;
      frames_shown <= frames_shown + CNT_W'(show);
      frames_dropped <= frames_dropped + CNT_W'(drop);
      frames_repeated <= frames_repeated + CNT_W'(rep);
      wr_base_addr <= BASE_ADDR + 32'(wr_n) * FRAME_BYTES;
      rd_base_addr <= BASE_ADDR + 32'(rd_n) * FRAME_BYTES;
    end
  end
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb_frame_buffer_scheduler: directed vector table plus random traffic against a buffer-role model
module tb_frame_buffer_scheduler;
  localparam int CNT_W = 16;
  localparam int FREE = 0, WRITER = 1, READER = 2, PENDING = 3;
  logic clk = 1'b0, rst = 1'b1, triple_en = 1'b1, wr_frame_done = 1'b0, rd_vsync = 1'b0;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic wr_stall, new_frame;
  logic [1:0] wr_idx, rd_idx;
  logic [CNT_W-1:0] frames_shown, frames_dropped, frames_repeated;
  int total = 0, bad = 0;

  frame_buffer_scheduler dut (
    .clk_100Mhz(clk), .rst(rst), .triple_en(triple_en), .wr_frame_done(wr_frame_done),
    .rd_vsync(rd_vsync), .wr_base_addr(wr_base_addr), .rd_base_addr(rd_base_addr),
    .wr_stall(wr_stall), .new_frame(new_frame), .wr_idx(wr_idx), .rd_idx(rd_idx),
    .frames_shown(frames_shown), .frames_dropped(frames_dropped), .frames_repeated(frames_repeated)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, t, d, v;
    int wr, rd;
    logic st, nf;
    int sh, dr, rp;
  } vec_t;
  vec_t tbl[27];

  // model: role held by each of the three buffers, plus double-mode pending flag
  int role[3];
  logic m_mode, m_pend, m_stall, m_nf;
  int m_sh, m_dr, m_rp;

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, step, act, exp);
    end
  endtask

  function automatic logic [31:0] addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0009_6000;
  endfunction

  function automatic int find(input int rl);
    for (int i = 0; i < 3; i++) if (role[i] == rl) return i;
    return -1;
  endfunction

  task automatic drive(input logic r, input logic t, input logic d, input logic v);
    @(negedge clk);
    rst = r;
    triple_en = t;
    wr_frame_done = d;
    rd_vsync = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int step, input int wr, input int rd, input logic st,
                           input logic nf, input int sh, input int dr, input int rp);
    check({tag, "_wr_idx"}, step, 32'(wr_idx), wr);
    check({tag, "_rd_idx"}, step, 32'(rd_idx), rd);
    check({tag, "_wr_base"}, step, wr_base_addr, addr(wr));
    check({tag, "_rd_base"}, step, rd_base_addr, addr(rd));
    check({tag, "_wr_stall"}, step, 32'(wr_stall), 32'(st));
    check({tag, "_new_frame"}, step, 32'(new_frame), 32'(nf));
    check({tag, "_shown"}, step, 32'(frames_shown), sh % 65536);
    check({tag, "_dropped"}, step, 32'(frames_dropped), dr % 65536);
    check({tag, "_repeated"}, step, 32'(frames_repeated), rp % 65536);
  endtask

  task automatic model(input logic r, input logic t, input logic d, input logic v);
    int w, rr, p, f;
    m_nf = 1'b0;
    if (r) begin
      role = '{WRITER, READER, FREE};
      m_mode = t; m_pend = 1'b0; m_stall = 1'b0;
      m_sh = 0; m_dr = 0; m_rp = 0;
      return;
    end
    w = find(WRITER); rr = find(READER); p = find(PENDING); f = find(FREE);
    if (m_mode) begin
      if (d && v) begin
        role[w] = READER;
        if (p >= 0) begin role[p] = WRITER; role[rr] = FREE; m_dr++; end
        else role[rr] = WRITER;
        m_sh++; m_nf = 1'b1;
      end else if (d) begin
        if (p >= 0) begin role[p] = WRITER; m_dr++; end
        else role[f] = WRITER;
        role[w] = PENDING;
      end else if (v) begin
        if (p >= 0) begin role[rr] = FREE; role[p] = READER; m_sh++; m_nf = 1'b1; end
        else m_rp++;
      end
    end else begin
      if (d && m_pend) m_dr++;
      if (v && (m_pend || d)) begin
        role[w] = READER; role[rr] = WRITER;
        m_pend = 1'b0; m_stall = 1'b0; m_sh++; m_nf = 1'b1;
      end else if (v) m_rp++;
      else if (d) begin m_pend = 1'b1; m_stall = 1'b1; end
    end
  endtask

  initial begin
    tbl[0]  = '{1,1,0,0, 0,1,0,0, 0,0,0};
    tbl[1]  = '{0,1,1,0, 2,1,0,0, 0,0,0};
    tbl[2]  = '{0,1,0,0, 2,1,0,0, 0,0,0};
    tbl[3]  = '{0,1,0,0, 2,1,0,0, 0,0,0};
    tbl[4]  = '{0,1,0,0, 2,1,0,0, 0,0,0};
    tbl[5]  = '{0,1,0,0, 2,1,0,0, 0,0,0};
    tbl[6]  = '{0,1,0,1, 2,0,0,1, 1,0,0};
    tbl[7]  = '{0,1,0,0, 2,0,0,0, 1,0,0};
    tbl[8]  = '{0,1,1,0, 1,0,0,0, 1,0,0};
    tbl[9]  = '{0,1,1,0, 2,0,0,0, 1,1,0};
    tbl[10] = '{0,1,0,1, 2,1,0,1, 2,1,0};
    tbl[11] = '{1,1,0,0, 0,1,0,0, 0,0,0};
    tbl[12] = '{0,1,1,1, 1,0,0,1, 1,0,0};
    tbl[13] = '{1,0,0,0, 0,1,0,0, 0,0,0};
    tbl[14] = '{0,0,1,0, 0,1,1,0, 0,0,0};
    tbl[15] = '{0,0,0,0, 0,1,1,0, 0,0,0};
    tbl[16] = '{0,0,0,1, 1,0,0,1, 1,0,0};
    tbl[17] = '{0,0,0,1, 1,0,0,0, 1,0,1};
    tbl[18] = '{0,0,0,1, 1,0,0,0, 1,0,2};
    tbl[19] = '{0,0,1,0, 1,0,1,0, 1,0,2};
    tbl[20] = '{0,0,1,0, 1,0,1,0, 1,1,2};
    tbl[21] = '{1,1,0,0, 0,1,0,0, 0,0,0};
    tbl[22] = '{0,0,1,0, 2,1,0,0, 0,0,0};
    tbl[23] = '{0,0,1,0, 0,1,0,0, 0,1,0};
    tbl[24] = '{1,0,0,0, 0,1,0,0, 0,0,0};
    tbl[25] = '{0,0,1,1, 1,0,0,1, 1,0,0};
    tbl[26] = '{0,0,0,0, 1,0,0,0, 1,0,0};
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].r, tbl[i].t, tbl[i].d, tbl[i].v);
      check_all("vec", i, tbl[i].wr, tbl[i].rd, tbl[i].st, tbl[i].nf, tbl[i].sh, tbl[i].dr, tbl[i].rp);
    end
    for (int i = 0; i < 3000; i++) begin
      logic r, t, d, v;
      r = (i == 0) || ($urandom_range(0, 199) == 0);
      t = 1'($urandom);
      d = ($urandom_range(0, 2) == 0);
      v = ($urandom_range(0, 3) == 0);
      model(r, t, d, v);
      drive(r, t, d, v);
      check_all("rnd", i, find(WRITER), find(READER), m_stall, m_nf, m_sh, m_dr, m_rp);
      check("rnd_distinct", i, 32'(wr_idx != rd_idx), 32'd1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
Owns frame-buffer allocation in DDR between the camera-side AXI4 writer and the HDMI-side AXI4 reader, all in the clk_100Mhz domain. It replaces the ad-hoc two-buffer swap flag with a scheduler supporting double or triple buffering. It hands each side a stable base address, decides the swap point at reader vsync, and counts dropped and repeated frames for ILA/VIO debug.

Parameters:
BASE_ADDR, 32'h1000_0000, DDR byte address of buffer 0
FRAME_BYTES, 32'h0009_6000, bytes per frame (640x480x2); buffer n base = BASE_ADDR + n*FRAME_BYTES
CNT_W, 16, width of statistics counters

Ports:
clk_100Mhz  in  1  AXI/system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
triple_en  in  1  1 = triple buffering (buffers 0..2), 0 = double (buffers 0..1); sampled only while rst=1
wr_frame_done  in  1  single-cycle pulse: writer finished all bursts (B responses received) of current frame
rd_vsync  in  1  single-cycle pulse (already synchronised vsync_sync2): reader about to start a new frame
wr_base_addr  out  32  base address the writer must use for its current/next frame
rd_base_addr  out  32  base address the reader must use for the frame it is scanning
wr_stall  out  1  1 = writer must not start a new frame (double mode, completed frame not yet shown)
new_frame  out  1  one-cycle pulse, cycle after reader takes a newly completed buffer
wr_idx  out  2  debug: writer buffer index
rd_idx  out  2  debug: reader buffer index
frames_shown  out  CNT_W  count of vsyncs that took a new buffer
frames_dropped  out  CNT_W  completed frames overwritten before being shown
frames_repeated  out  CNT_W  vsyncs with no new buffer (reader re-scans old one)

Behaviour:
- Internal state: wr_idx, rd_idx, rdy_idx (2b each), rdy_valid, mode (latched triple_en).
- Reset (rst=1 at clock edge): wr_idx=0, rd_idx=1, rdy_idx=2, rdy_valid=0, mode<=triple_en, wr_stall=0, new_frame=0, all counters=0. So wr_base_addr=BASE_ADDR, rd_base_addr=BASE_ADDR+FRAME_BYTES. Reset mid-frame abandons all ownership; no pending state survives.
- Addresses: registered, updated same edge as indices; computed as BASE_ADDR + idx*FRAME_BYTES in 32b, wrap-around ignored. Indices change only on the events below, so addresses are stable for a whole frame.
- Triple mode, wr_frame_done only: if rdy_valid, frames_dropped++, new wr_idx=old rdy_idx; else new wr_idx=rdy_idx (free buffer). Then rdy_idx<=old wr_idx, rdy_valid<=1. wr_stall stays 0.
- Triple mode, rd_vsync only: if rdy_valid, swap rd_idx<->rdy_idx, rdy_valid<=0, frames_shown++, new_frame=1 next cycle; else frames_repeated++, no index change.
- Triple mode, both same cycle: the frame just completed goes straight to the reader: rd_idx<=wr_idx, wr_idx<=old rd_idx (or old rdy_idx if rdy_valid, which is then dropped: frames_dropped++, rdy_idx<=old rd_idx), rdy_valid<=0, frames_shown++, new_frame pulse.
- Invariant (checked by bench): wr_idx, rd_idx, rdy_idx pairwise distinct in triple mode.
- Double mode (rdy_idx unused, values 0/1 only): wr_frame_done sets rdy_valid=1, wr_stall=1 (registered, visible next cycle). wr_frame_done while rdy_valid=1 is a protocol violation: frames_dropped++, no state change. rd_vsync with rdy_valid: swap wr_idx<->rd_idx, rdy_valid=0, wr_stall=0, frames_shown++, new_frame pulse. rd_vsync without: frames_repeated++. Both same cycle: wr_frame_done first, then swap in the same edge; result = swap, rdy_valid=0, wr_stall=0.
- Counters wrap at 2^CNT_W; no saturation.
- triple_en changes outside reset are ignored.
- Latency: every output reflects an event on the edge after the event cycle (1 cycle).

Test Plan:
- Reset, triple_en=1 -> wr_base=0x1000_0000, rd_base=0x1009_6000, all counters 0, wr_stall=0.
- Triple: wr_frame_done, 5 cycles later rd_vsync -> wr_base=0x1012_C000 after done; after vsync rd_base=0x1000_0000, new_frame one cycle high, frames_shown=1.
- Triple: two wr_frame_done before any vsync -> frames_dropped=1, next vsync rd_base = second-completed buffer (0x1012_C000), indices stay distinct.
- Triple: wr_frame_done and rd_vsync same cycle from reset -> rd_idx=0, wr_idx=1, rdy_valid=0, frames_shown=1, frames_dropped=0.
- Double (triple_en=0 at reset): wr_frame_done -> wr_stall=1 next cycle; 3 rd_vsync... first vsync swaps (wr_base=0x1009_6000, rd_base=0x1000_0000, wr_stall=0); following 2 vsyncs -> frames_repeated=2.
- Assert rst mid-sequence with rdy_valid=1 and wr_stall=1 -> next cycle all outputs at reset values; triple_en toggled after reset -> no mode change.
